// File: rtl/spram_frame_buf.sv
`default_nettype none
// spram_frame_buf: byte- or word-wide frame buffer over 1..4 SP256K-style single-port RAMs,
// with write-priority arbitration, a 2-cycle read pipeline and idle-driven standby.

module spram_frame_buf_sp256k (
  input  logic        ck_i,
  input  logic [13:0] ad_i,
  input  logic [15:0] di_i,
  input  logic [3:0]  maskwe_i,
  input  logic        we_i,
  input  logic        cs_i,
  input  logic        stdby_i,
  input  logic        sleep_i,
  input  logic        pwroff_n_i,
  output logic [15:0] do_o
);
  logic [15:0] mem_q [16384];
  logic        en_w;

  assign en_w = cs_i & ~stdby_i & ~sleep_i & pwroff_n_i;

  // Nibble-granular write enables; the output register only moves on reads.
  always_ff @(posedge ck_i) begin
    if (en_w) begin
      if (we_i) begin
        for (int n = 0; n < 4; n++) begin
          if (maskwe_i[n]) mem_q[ad_i][n*4 +: 4] <= di_i[n*4 +: 4];
        end
      end else begin
        do_o <= mem_q[ad_i];
      end
    end
  end
endmodule

module spram_frame_buf #(
  parameter  int LANE_W   = 8,
  parameter  int BANKS    = 4,
  parameter  int IDLE_CYC = 64,
  localparam int BW       = $clog2(BANKS),
  localparam int LW       = (LANE_W == 8) ? 1 : 0,
  localparam int AW       = 14 + BW + LW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [LANE_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic [AW-1:0]     rd_addr,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [LANE_W-1:0] rd_data,
  output logic              stby
);
  localparam int            CW       = (IDLE_CYC > 0) ? $clog2(IDLE_CYC + 1) : 1;
  localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_CYC);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_STBY   = 2'd1,
    ST_WAKE   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     idle_cnt_q, idle_cnt_d;
  logic              s1_valid_q, rd_valid_q;
  logic [LANE_W-1:0] rd_data_q, rd_data_d;
  logic              active_w, wr_acc_w, rd_acc_w, stdby_w;
  logic [13:0]       ad_w;
  logic [15:0]       di_w, sel_do_w;
  logic [3:0]        mask_w;
  logic [BANKS-1:0]  bank_we_w;
  logic [15:0]       do_w [BANKS];

  // Reset keeps wr_ready high (state is ACTIVE) but blocks every acceptance.
  assign active_w = (state_q == ST_ACTIVE) && !reset;
  assign wr_acc_w = wr_en & active_w;
  assign rd_acc_w = rd_req & ~wr_en & active_w;
  assign wr_ready = (state_q == ST_ACTIVE);
  assign rd_ready = active_w & ~wr_en;
  assign stby     = (state_q == ST_STBY);
  assign stdby_w  = stby;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign ad_w     = wr_acc_w ? wr_addr[AW-1 -: 14] : rd_addr[AW-1 -: 14];

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      ST_ACTIVE: begin
        if (wr_acc_w || rd_acc_w) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q != IDLE_MAX) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
        if ((IDLE_CYC != 0) && (idle_cnt_q == IDLE_MAX) && !wr_en && !rd_req &&
            !s1_valid_q && !rd_valid_q) begin
          state_d = ST_STBY;
        end
      end
      ST_STBY: begin
        idle_cnt_d = '0;
        if (wr_en || rd_req) state_d = ST_WAKE;
      end
      ST_WAKE: begin
        idle_cnt_d = '0;
        state_d    = ST_ACTIVE;
      end
      default: begin
        idle_cnt_d = '0;
        state_d    = ST_ACTIVE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_ACTIVE;
      idle_cnt_q <= '0;
      s1_valid_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      s1_valid_q <= rd_acc_w;
      rd_valid_q <= s1_valid_q;
      if (s1_valid_q) rd_data_q <= rd_data_d;
    end
  end

  generate
    if (BW > 0) begin : g_bank_sel
      logic [BW-1:0] s1_bank_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s1_bank_q <= '0;
        end else if (rd_acc_w) begin
          s1_bank_q <= rd_addr[LW +: BW];
        end
      end

      always_comb begin
        bank_we_w = '0;
        sel_do_w  = do_w[0];
        for (int b = 0; b < BANKS; b++) begin
          if (wr_addr[LW +: BW] == BW'(b)) bank_we_w[b] = wr_acc_w;
          if (s1_bank_q == BW'(b)) sel_do_w = do_w[b];
        end
      end
    end else begin : g_single_bank
      assign bank_we_w = wr_acc_w;
      assign sel_do_w  = do_w[0];
    end

    if (LANE_W == 8) begin : g_lane8
      logic s1_lane_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s1_lane_q <= 1'b0;
        end else if (rd_acc_w) begin
          s1_lane_q <= rd_addr[0];
        end
      end

      assign di_w      = {wr_data, wr_data};
      assign mask_w    = wr_addr[0] ? 4'b1100 : 4'b0011;
      assign rd_data_d = s1_lane_q ? sel_do_w[15:8] : sel_do_w[7:0];
    end else begin : g_lane16
      assign di_w      = wr_data;
      assign mask_w    = 4'b1111;
      assign rd_data_d = sel_do_w;
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_ram
      spram_frame_buf_sp256k u_ram (
        .ck_i       (clk),
        .ad_i       (ad_w),
        .di_i       (di_w),
        .maskwe_i   (mask_w),
        .we_i       (bank_we_w[b]),
        .cs_i       (1'b1),
        .stdby_i    (stdby_w),
        .sleep_i    (1'b0),
        .pwroff_n_i (1'b1),
        .do_o       (do_w[b])
      );
    end
  endgenerate
endmodule

`default_nettype wire

// File: tb/tb_spram_frame_buf.sv
`default_nettype none
// tb_spram_frame_buf: scoreboard bench; instance A is byte-lane/4-bank/IDLE_CYC=4,
// instance B is 16-bit/1-bank with standby disabled.

module tb_spram_frame_buf;
  localparam int AW_A = 17;
  localparam int AW_B = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic            a_wr_en, a_rd_req, a_wr_ready, a_rd_ready, a_rd_valid, a_stby;
  logic [AW_A-1:0] a_wr_addr, a_rd_addr;
  logic [7:0]      a_wr_data, a_rd_data;

  logic            b_wr_en, b_rd_req, b_wr_ready, b_rd_ready, b_rd_valid, b_stby;
  logic [AW_B-1:0] b_wr_addr, b_rd_addr;
  logic [15:0]     b_wr_data, b_rd_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t       qa[$], qb[$];
  exp_t       ea, eb;
  logic [7:0]  mem_a [int];
  logic [15:0] mem_b [int];

  spram_frame_buf #(.LANE_W(8), .BANKS(4), .IDLE_CYC(4)) u_dut_a (
    .clk(clk), .reset(reset),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_ready(a_wr_ready),
    .rd_req(a_rd_req), .rd_addr(a_rd_addr), .rd_ready(a_rd_ready),
    .rd_valid(a_rd_valid), .rd_data(a_rd_data), .stby(a_stby)
  );

  spram_frame_buf #(.LANE_W(16), .BANKS(1), .IDLE_CYC(0)) u_dut_b (
    .clk(clk), .reset(reset),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_ready(b_wr_ready),
    .rd_req(b_rd_req), .rd_addr(b_rd_addr), .rd_ready(b_rd_ready),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data), .stby(b_stby)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard pop side: every rd_valid pulse must match the oldest expectation, data and cycle.
  always @(negedge clk) begin
    if (a_rd_valid === 1'b1) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_valid: rd_data=%h at cycle %0d, required no pulse", a_rd_data, cyc);
      end else begin
        ea = qa.pop_front();
        if (a_rd_data !== ea.data[7:0] || cyc != ea.due) begin
          errors++;
          $display("FAIL a_read: data=%h cycle=%0d, required data=%h cycle=%0d",
                   a_rd_data, cyc, ea.data[7:0], ea.due);
        end
      end
    end
    if (b_rd_valid === 1'b1) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_valid: rd_data=%h at cycle %0d, required no pulse", b_rd_data, cyc);
      end else begin
        eb = qb.pop_front();
        if (b_rd_data !== eb.data || cyc != eb.due) begin
          errors++;
          $display("FAIL b_read: data=%h cycle=%0d, required data=%h cycle=%0d",
                   b_rd_data, cyc, eb.data, eb.due);
        end
      end
    end
  end

  task automatic a_write(input logic [AW_A-1:0] addr, input logic [7:0] data);
    int n;
    n = 0;
    a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data;
    #1;
    while (a_wr_ready !== 1'b1 && n < 10) begin @(negedge clk); #1; n++; end
    if (a_wr_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL a_write_timeout: wr_ready=%b, required 1 within 10 cycles", a_wr_ready);
    end else begin
      mem_a[int'(addr)] = data;
    end
    @(negedge clk);
    a_wr_en = 1'b0;
  endtask

  task automatic a_read(input logic [AW_A-1:0] addr);
    int n;
    n = 0;
    a_rd_req = 1'b1; a_rd_addr = addr;
    #1;
    while (a_rd_ready !== 1'b1 && n < 10) begin @(negedge clk); #1; n++; end
    if (a_rd_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL a_read_timeout: rd_ready=%b, required 1 within 10 cycles", a_rd_ready);
    end else begin
      qa.push_back('{data: {8'h00, mem_a[int'(addr)]}, due: cyc + 2});
    end
    @(negedge clk);
    a_rd_req = 1'b0;
  endtask

  task automatic b_write(input logic [AW_B-1:0] addr, input logic [15:0] data);
    int n;
    n = 0;
    b_wr_en = 1'b1; b_wr_addr = addr; b_wr_data = data;
    #1;
    while (b_wr_ready !== 1'b1 && n < 10) begin @(negedge clk); #1; n++; end
    if (b_wr_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL b_write_timeout: wr_ready=%b, required 1 within 10 cycles", b_wr_ready);
    end else begin
      mem_b[int'(addr)] = data;
    end
    @(negedge clk);
    b_wr_en = 1'b0;
  endtask

  task automatic b_read(input logic [AW_B-1:0] addr);
    int n;
    n = 0;
    b_rd_req = 1'b1; b_rd_addr = addr;
    #1;
    while (b_rd_ready !== 1'b1 && n < 10) begin @(negedge clk); #1; n++; end
    if (b_rd_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL b_read_timeout: rd_ready=%b, required 1 within 10 cycles", b_rd_ready);
    end else begin
      qb.push_back('{data: mem_b[int'(addr)], due: cyc + 2});
    end
    @(negedge clk);
    b_rd_req = 1'b0;
  endtask

  task automatic drain_a(input string name);
    repeat (4) @(negedge clk);
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d reads outstanding, required 0", name, qa.size());
      qa.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_wr_en = 1'b0; a_rd_req = 1'b1; a_wr_addr = '0; a_rd_addr = '0; a_wr_data = '0;
    b_wr_en = 1'b0; b_rd_req = 1'b1; b_wr_addr = '0; b_rd_addr = '0; b_wr_data = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (a_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b, required 1", a_wr_ready); end
    checks++; if (a_rd_ready !== 1'b0) begin errors++; $display("FAIL reset_rd_ready: got %b, required 0", a_rd_ready); end
    checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b, required 0", a_rd_valid); end
    checks++; if (a_rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h, required 00", a_rd_data); end
    checks++; if (a_stby !== 1'b0) begin errors++; $display("FAIL reset_stby: got %b, required 0", a_stby); end
    checks++; if (b_rd_data !== 16'h0000) begin errors++; $display("FAIL reset_b_rd_data: got %h, required 0000", b_rd_data); end
    @(negedge clk);
    a_rd_req = 1'b0; b_rd_req = 1'b0; reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill_readback();
    for (int i = 0; i < 256; i++) a_write(AW_A'(i), 8'(i));
    for (int i = 0; i < 256; i++) a_read(AW_A'(i));
    drain_a("fill");
  endtask

  task automatic test_lane_mask();
    a_write(17'd5, 8'hA5);
    a_write(17'd4, 8'h3C);
    a_read(17'd5);
    a_read(17'd4);
    drain_a("lane_mask");
  endtask

  task automatic test_arbitration();
    a_write(17'h40, 8'h11);
    for (int i = 0; i < 3; i++) begin
      a_wr_en = 1'b1; a_wr_addr = AW_A'(17'h80 + i); a_wr_data = 8'(8'hC0 + i);
      a_rd_req = 1'b1; a_rd_addr = 17'h82;
      #1;
      checks++; if (a_rd_ready !== 1'b0) begin errors++; $display("FAIL arb_rd_ready_c%0d: got %b, required 0", i, a_rd_ready); end
      checks++; if (a_wr_ready !== 1'b1) begin errors++; $display("FAIL arb_wr_ready_c%0d: got %b, required 1", i, a_wr_ready); end
      mem_a[32'h80 + i] = 8'(8'hC0 + i);
      @(negedge clk);
    end
    a_wr_en = 1'b0;
    #1;
    checks++;
    if (a_rd_ready !== 1'b1) begin
      errors++; $display("FAIL arb_rd_ready_c3: got %b, required 1", a_rd_ready);
    end else begin
      qa.push_back('{data: {8'h00, mem_a[32'h82]}, due: cyc + 2});
    end
    @(negedge clk);
    a_rd_req = 1'b0;
    a_read(17'h80);
    a_read(17'h81);
    drain_a("arb");
  endtask

  task automatic test_standby();
    int n;
    a_write(17'h1234, 8'h5A);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (a_stby !== 1'b0) begin errors++; $display("FAIL stby_early_%0d: got %b, required 0", i, a_stby); end
      @(negedge clk);
    end
    n = 0;
    while (a_stby !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    #1;
    checks++; if (a_stby !== 1'b1) begin errors++; $display("FAIL stby_enter: got %b, required 1", a_stby); end
    checks++; if (a_wr_ready !== 1'b0) begin errors++; $display("FAIL stby_wr_ready: got %b, required 0", a_wr_ready); end
    a_wr_en = 1'b1; a_wr_addr = 17'h1235; a_wr_data = 8'hA7;
    #1;
    checks++; if (a_wr_ready !== 1'b0) begin errors++; $display("FAIL stby_req_cycle_ready: got %b, required 0", a_wr_ready); end
    @(negedge clk); #1;
    checks++; if (a_stby !== 1'b0) begin errors++; $display("FAIL wake_stby: got %b, required 0", a_stby); end
    checks++; if (a_wr_ready !== 1'b0) begin errors++; $display("FAIL wake_wr_ready: got %b, required 0", a_wr_ready); end
    @(negedge clk); #1;
    checks++; if (a_wr_ready !== 1'b1) begin errors++; $display("FAIL wake_accept: got %b, required 1", a_wr_ready); end
    mem_a[32'h1235] = 8'hA7;
    @(negedge clk);
    a_wr_en = 1'b0;
    a_read(17'h1234);
    a_read(17'h1235);
    drain_a("standby");
  endtask

  task automatic test_wide();
    b_write(14'h3FFF, 16'hBEEF);
    b_write(14'h0000, 16'h1234);
    b_read(14'h3FFF);
    b_read(14'h0000);
    repeat (4) @(negedge clk);
    #1;
    checks++; if (qb.size() != 0) begin errors++; $display("FAIL wide_drain: %0d outstanding, required 0", qb.size()); qb.delete(); end
    checks++; if (b_rd_data !== 16'h1234) begin errors++; $display("FAIL wide_hold: got %h, required 1234", b_rd_data); end
    checks++; if (b_stby !== 1'b0) begin errors++; $display("FAIL wide_no_stby: got %b, required 0", b_stby); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    a_write(17'h77, 8'h99);
    a_rd_req = 1'b1; a_rd_addr = 17'h77;
    #1;
    checks++; if (a_rd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_rd_ready: got %b, required 1", a_rd_ready); end
    @(negedge clk);
    a_rd_req = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (a_rd_data !== 8'h00) begin errors++; $display("FAIL rst_mid_rd_data: got %h, required 00", a_rd_data); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid_%0d: got %b, required 0", i, a_rd_valid); end
      checks++; if (a_rd_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data_%0d: got %h, required 00", i, a_rd_data); end
      @(negedge clk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_readback();
    test_lane_mask();
    test_arbitration();
    test_standby();
    test_wide();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/spram_frame_buf.md
SPRAM_FRAME_BUF -- requirements
Module: spram_frame_buf

Interface
REQ-001 SHALL have parameter LANE_W, default 8, meaning buffer word width in bits; legal values are 8 (half-SPRAM-word lanes) and 16 (full SPRAM word).
REQ-002 SHALL have parameter BANKS, default 4, meaning the number of SP256K instances; legal values are 1, 2 and 4.
REQ-003 SHALL have parameter IDLE_CYC, default 64, meaning idle cycles before standby; 0 disables standby.
REQ-004 SHALL derive localparam AW = 14 + log2(BANKS) + (LANE_W==8 ? 1 : 0), the address width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock for all logic and all SPRAM CK pins.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port wr_en, input, 1 bit: write request.
REQ-008 SHALL have port wr_addr, input, AW bits: write word address.
REQ-009 SHALL have port wr_data, input, LANE_W bits: write data.
REQ-010 SHALL have port wr_ready, output, 1 bit: write accepted when wr_en and wr_ready are both high.
REQ-011 SHALL have port rd_req, input, 1 bit: read request.
REQ-012 SHALL have port rd_addr, input, AW bits: read word address.
REQ-013 SHALL have port rd_ready, output, 1 bit: read accepted when rd_req and rd_ready are both high.
REQ-014 SHALL have port rd_valid, output, 1 bit: single-cycle pulse marking rd_data valid.
REQ-015 SHALL have port rd_data, output, LANE_W bits: read data; holds its last value between pulses.
REQ-016 SHALL have port stby, output, 1 bit: high while the SPRAMs are in standby.

Function
REQ-017 SHALL map addresses (LSB first) as: lane bit (LANE_W=8 only; 0 = DO[7:0], 1 = DO[15:8]), then log2(BANKS) bank-select bits, then the upper 14 bits as SPRAM AD.
REQ-018 SHALL, for LANE_W=8, drive DI = {wr_data, wr_data} with MASKWE 4'b0011 for lane 0 and 4'b1100 for lane 1; for LANE_W=16, SHALL drive MASKWE 4'b1111.
REQ-019 SHALL assert WE only on the selected bank, and only for an accepted write.
REQ-020 SHALL use a single-port arbiter with write priority: in ACTIVE, wr_ready = 1 and rd_ready = ~wr_en.
REQ-021 SHALL, on a read accepted in cycle N, pulse rd_valid and present data in cycle N+2 (SPRAM output, then the bank/lane mux register); fully pipelined, one read per cycle.
REQ-022 SHALL carry bank and lane select through the pipeline so a write in cycle N+1 does not corrupt the read returning in N+2; rd_data is never zeroed by writes.
REQ-023 SHALL return the newly written data for a read accepted in the cycle after a write to the same address.
REQ-024 SHALL implement an FSM with states ACTIVE, STBY and WAKE.
REQ-025 SHALL, in ACTIVE, clear idle_cnt on any accepted access and otherwise increment it, saturating at IDLE_CYC; when idle_cnt == IDLE_CYC and IDLE_CYC != 0 and no request is present, the FSM SHALL move to STBY.
REQ-026 SHALL, in STBY, drive STDBY = 1, stby = 1, and wr_ready = rd_ready = 0; wr_en or rd_req SHALL move the FSM to WAKE.
REQ-027 SHALL, in WAKE, drive STDBY = 0 and ready = 0 for exactly one cycle, then move to ACTIVE with idle_cnt = 0.
REQ-028 SHALL not enter STBY while any read is in flight; pending rd_valid pulses complete first.
REQ-029 SHALL tie CS = 1, SLEEP = 0 and PWROFF_N = 1.

Reset
REQ-030 SHALL, while reset is high, force state ACTIVE, idle_cnt = 0, rd_valid = 0, rd_data = 0, stby = 0, wr_ready = 1 and rd_ready = 0; SPRAM contents are undefined.
REQ-031 SHALL discard reads in flight when reset asserts mid-operation; no rd_valid SHALL follow reset release.

Verification
REQ-032 SHALL pass this scenario (LANE_W=8, BANKS=4): write 0x00..0xFF to addresses 0..255, then read back 0..255 -> rd_valid 2 cycles after each accept, data equal to the address.
REQ-033 SHALL pass this scenario: write addr 5 = 0xA5 and addr 4 = 0x3C, then read 5 and 4 -> 0xA5 and 0x3C (lane masking leaves the shared word intact).
REQ-034 SHALL pass this scenario: wr_en and rd_req both high for 3 cycles -> rd_ready = 0 throughout, all 3 writes land, and the read is accepted in cycle 4.
REQ-035 SHALL pass this scenario (IDLE_CYC=4): 4 idle cycles -> stby = 1; then wr_en -> WAKE, with the write accepted on the 2nd cycle after the request and data retained.
REQ-036 SHALL pass this scenario: read issued, then reset asserted the next cycle -> rd_valid stays 0 and rd_data = 0.
REQ-037 SHALL pass this scenario (LANE_W=16, BANKS=1): write 0xBEEF to addr 0x3FFF, then read -> 0xBEEF.
